hazard_ctrl: RTL and testbench

- ID/EX-side interlock for the 5-stage RISC-V pipeline. It is the producer-side counterpart of the EX forwarding network: it decides when a value cannot be forwarded and the pipeline must stall, bubble, flush or freeze.
- Handles load-use bubbles, taken-branch flushes and data-memory wait states, with a timeout watchdog and performance counters.
- Sits beside the ID stage and drives the PC and pipeline-register write-enables and flushes.

---
 rtl/hazard_ctrl_pkg.sv | 50 +++++
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl_sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ID/EX hazard interlock: FSM encoding,
// register constants and the control-bundle helpers.
package hazard_ctrl_pkg;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int CNT_W_DEFAULT    = 32;
  localparam int MAX_WAIT_DEFAULT = 16;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExFlush;
    logic freeze;
  } ctrlBundle_t;

  // Everything held while data memory is stalled or the watchdog has fired.
  localparam ctrlBundle_t FREEZE_CTRL = '{pcWrite: 1'b0, ifIdWrite: 1'b0,
                                          ifIdFlush: 1'b0, idExFlush: 1'b0,
                                          freeze: 1'b1};

  // A source operand only matters when the instruction actually reads it.
  function automatic logic srcMatch(input logic used, input logic [4:0] src,
                                    input logic [4:0] dst);
    return used && (src == dst);
  endfunction

  // Unfrozen decode: a taken branch wins over load-use, since the
  // instruction that would have needed the bubble is flushed anyway.
  function automatic ctrlBundle_t runDecode(input logic branch, input logic loadUse);
    ctrlBundle_t c;
    c = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifIdFlush: 1'b0, idExFlush: 1'b0,
          freeze: 1'b0};
    if (branch) begin
      c.ifIdFlush = 1'b1;
      c.idExFlush = 1'b1;
    end else if (loadUse) begin
      c.pcWrite   = 1'b0;
      c.ifIdWrite = 1'b0;
      c.idExFlush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the interlock: decode information flowing in from
// ID/EX/MEM and the enable/flush controls flowing back out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0] rs1Addr_id;
  logic [4:0] rs2Addr_id;
  logic       rs1Used_id;
  logic       rs2Used_id;
  logic       MemRead_ex;
  logic [4:0] rdAddr_ex;
  logic       MemReq_mem;
  logic       MemReady_mem;
  logic       BranchTaken_ex;

  logic       PCWrite;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       Freeze;

  modport master (
    output rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           MemRead_ex, rdAddr_ex, MemReq_mem, MemReady_mem, BranchTaken_ex,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Freeze
  );

  modport slave (
    input  rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           MemRead_ex, rdAddr_ex, MemReq_mem, MemReady_mem, BranchTaken_ex,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Freeze
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the interlock performance statistics;
// it sticks at all-ones rather than wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, holding at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX interlock: decides stall, bubble, flush or freeze for the 5-stage
// pipeline, watches data-memory wait states and counts lost cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic [1:0]     state;
  logic [1:0]     stateNext;
  logic [WCW-1:0] waitCnt;
  logic [WCW-1:0] waitCntNext;
  logic           loadUse;
  logic           memWait;
  ctrlBundle_t    ctrl;

  assign memWait = hz.MemReq_mem && !hz.MemReady_mem;
  assign loadUse = hz.MemRead_ex && (hz.rdAddr_ex != REG_ZERO) &&
                   (srcMatch(hz.rs1Used_id, hz.rs1Addr_id, hz.rdAddr_ex) ||
                    srcMatch(hz.rs2Used_id, hz.rs2Addr_id, hz.rdAddr_ex));

  // Control outputs and next state from the registered mode and live inputs.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    ctrl        = runDecode(hz.BranchTaken_ex, loadUse);
    case (state)
      RUN: begin
        if (memWait) begin
          ctrl        = FREEZE_CTRL;
          stateNext   = WAIT;
          waitCntNext = WCW'(1);
        end
      end
      WAIT: begin
        if (memWait) begin
          ctrl = FREEZE_CTRL;
          if (waitCnt == WCW'(MAX_WAIT - 1)) begin
            stateNext = ERR;
          end else begin
            waitCntNext = waitCnt + WCW'(1);
          end
        end else begin
          stateNext   = RUN;
          waitCntNext = '0;
        end
      end
      ERR: begin
        ctrl = FREEZE_CTRL;
      end
      default: begin
        ctrl        = FREEZE_CTRL;
        stateNext   = RUN;
        waitCntNext = '0;
      end
    endcase
  end

  // Mode, wait-cycle count and the sticky watchdog flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (stateNext == ERR) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  assign hz.PCWrite     = ctrl.pcWrite;
  assign hz.IF_ID_Write = ctrl.ifIdWrite;
  assign hz.IF_ID_Flush = ctrl.ifIdFlush;
  assign hz.ID_EX_Flush = ctrl.idExFlush;
  assign hz.Freeze      = ctrl.freeze;

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!ctrl.pcWrite),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.ifIdFlush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected responses
// computed from a cycle-level reference model; a monitor pops and compares.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int SAT      = (1 << CNT_W) - 1;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         u1;
    bit         u2;
    bit         memRead;
    logic [4:0] rd;
    bit         req;
    bit         rdy;
    bit         br;
  } stim_t;

  typedef struct {
    bit    pcWrite;
    bit    ifIdWrite;
    bit    ifIdFlush;
    bit    idExFlush;
    bit    freeze;
    bit    timeout;
    int    stall;
    int    flush;
    string tag;
  } expect_t;

  logic             clk;
  logic             rst_n;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hz          (hz),
    .mem_timeout (memTimeout),
    .stall_cnt   (stallCnt),
    .flush_cnt   (flushCnt)
  );

  expect_t sbQ[$];
  int      checks = 0;
  int      errors = 0;

  // Reference model: consecutive memory-wait run length, watchdog latch
  // and the two statistics counters.
  int mWaitRun = 0;
  bit mDead    = 0;
  int mStall   = 0;
  int mFlush   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idleStim();
    stim_t s;
    s = '{rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, memRead: 1'b0,
          rd: 5'd0, req: 1'b0, rdy: 1'b0, br: 1'b0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rs1     = 5'($urandom_range(0, 3));
    s.rs2     = 5'($urandom_range(0, 3));
    s.u1      = 1'($urandom_range(0, 1));
    s.u2      = 1'($urandom_range(0, 1));
    s.memRead = 1'($urandom_range(0, 1));
    s.rd      = 5'($urandom_range(0, 3));
    s.req     = ($urandom_range(0, 9) < 3);
    s.rdy     = ($urandom_range(0, 9) < 5);
    s.br      = ($urandom_range(0, 9) < 2);
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    hz.rs1Addr_id     = s.rs1;
    hz.rs2Addr_id     = s.rs2;
    hz.rs1Used_id     = s.u1;
    hz.rs2Used_id     = s.u2;
    hz.MemRead_ex     = s.memRead;
    hz.rdAddr_ex      = s.rd;
    hz.MemReq_mem     = s.req;
    hz.MemReady_mem   = s.rdy;
    hz.BranchTaken_ex = s.br;
  endtask

  task automatic applyStimulus(input stim_t s, input string tag);
    expect_t e;
    bit      memStall;
    bit      hazard;
    @(negedge clk);
    driveInputs(s);
    memStall = s.req && !s.rdy;
    hazard   = s.memRead && (s.rd != 5'd0) &&
               ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    e.tag     = tag;
    e.timeout = mDead;
    e.stall   = mStall;
    e.flush   = mFlush;
    e.pcWrite   = 1'b1;
    e.ifIdWrite = 1'b1;
    e.ifIdFlush = 1'b0;
    e.idExFlush = 1'b0;
    e.freeze    = 1'b0;
    if (mDead || memStall) begin
      e.pcWrite   = 1'b0;
      e.ifIdWrite = 1'b0;
      e.freeze    = 1'b1;
    end else if (s.br) begin
      e.ifIdFlush = 1'b1;
      e.idExFlush = 1'b1;
    end else if (hazard) begin
      e.pcWrite   = 1'b0;
      e.ifIdWrite = 1'b0;
      e.idExFlush = 1'b1;
    end
    sbQ.push_back(e);
    if (!mDead) begin
      if (memStall) begin
        mWaitRun++;
        if (mWaitRun >= MAX_WAIT) mDead = 1'b1;
      end else begin
        mWaitRun = 0;
      end
    end
    if (!e.pcWrite && mStall < SAT) mStall++;
    if (e.ifIdFlush && mFlush < SAT) mFlush++;
  endtask

  task automatic applyReset(input string tag);
    expect_t e;
    @(negedge clk);
    driveInputs(idleStim());
    #1;
    rst_n    = 1'b0;
    mWaitRun = 0;
    mDead    = 1'b0;
    mStall   = 0;
    mFlush   = 0;
    e = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifIdFlush: 1'b0, idExFlush: 1'b0,
          freeze: 1'b0, timeout: 1'b0, stall: 0, flush: 0, tag: tag};
    sbQ.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput({e.tag, ".PCWrite"},     32'(hz.PCWrite),     32'(e.pcWrite));
        checkOutput({e.tag, ".IF_ID_Write"}, 32'(hz.IF_ID_Write), 32'(e.ifIdWrite));
        checkOutput({e.tag, ".IF_ID_Flush"}, 32'(hz.IF_ID_Flush), 32'(e.ifIdFlush));
        checkOutput({e.tag, ".ID_EX_Flush"}, 32'(hz.ID_EX_Flush), 32'(e.idExFlush));
        checkOutput({e.tag, ".Freeze"},      32'(hz.Freeze),      32'(e.freeze));
        checkOutput({e.tag, ".mem_timeout"}, 32'(memTimeout),     32'(e.timeout));
        checkOutput({e.tag, ".stall_cnt"},   32'(stallCnt),       32'(e.stall));
        checkOutput({e.tag, ".flush_cnt"},   32'(flushCnt),       32'(e.flush));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached, queue=%0d", sbQ.size());
    $fatal(1, "[TB] time limit");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    stim_t s;
    rst_n = 1'b0;
    driveInputs(idleStim());

    applyReset("reset");

    s = idleStim(); s.memRead = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1;
    applyStimulus(s, "loaduse");
    applyStimulus(idleStim(), "loaduseAfter");

    s = idleStim(); s.memRead = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1;
    applyStimulus(s, "x0Mask");
    s = idleStim(); s.memRead = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 0;
    s.rs2 = 5'd3; s.u2 = 1;
    applyStimulus(s, "unusedMask");

    s = idleStim(); s.memRead = 1; s.rd = 5'd9; s.rs1 = 5'd9; s.u1 = 1; s.br = 1;
    applyStimulus(s, "branchVsLu");
    applyStimulus(idleStim(), "branchAfter");

    s = idleStim(); s.req = 1; s.rdy = 0; s.br = 1;
    for (int i = 0; i < 3; i++) applyStimulus(s, "memWait");
    s.rdy = 1;
    applyStimulus(s, "memReady");
    applyStimulus(idleStim(), "memAfter");

    applyReset("resetPreTimeout");
    s = idleStim(); s.memRead = 1; s.rd = 5'd4; s.rs1 = 5'd4; s.u1 = 1;
    for (int i = 0; i < 6; i++) applyStimulus(s, "preTimeoutLu");
    s = idleStim(); s.req = 1; s.rdy = 0;
    for (int i = 0; i < MAX_WAIT; i++) applyStimulus(s, "timeoutWait");
    applyStimulus(idleStim(), "errIdle");
    for (int i = 0; i < 4; i++) applyStimulus(randStim(), "errHold");
    applyReset("resetFromErr");
    applyStimulus(idleStim(), "afterErrReset");

    s = idleStim(); s.memRead = 1; s.rd = 5'd12; s.rs2 = 5'd12; s.u2 = 1;
    for (int i = 0; i < 20; i++) applyStimulus(s, "saturate");

    for (int n = 0; n < 600; n++) begin
      if (n % 75 == 0) applyReset("randReset");
      applyStimulus(randStim(), "random");
    end

    for (int i = 0; i < 5 && sbQ.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #3;
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain actual=%0d expected=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
